// File: rtl/counter_mon_pkg.sv
// Shared types for the counter wrap monitor: event kinds, FIFO entry layout
// and the monitor's sequencing states.
package counter_mon_pkg;

    localparam int CNT_WIDTH = 3;
    localparam int EV_DEPTH  = 4;

    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_WRAP_UP = 3'd1,
        EV_WRAP_DN = 3'd2,
        EV_DIR     = 3'd3,
        EV_JUMP    = 3'd4
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t               kind;
        logic [CNT_WIDTH-1:0]   value;
    } ev_entry_t;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } mon_state_t;

    function automatic logic is_wrap(input ev_kind_t kind);
        return (kind == EV_WRAP_UP) || (kind == EV_WRAP_DN);
    endfunction

endpackage

// File: rtl/counter_wrap_monitor_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop
// retires the head in the same cycle. Head reads as zero while empty.
module event_fifo
    import counter_mon_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ev_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t push_data_i,
    output logic   full_o,
    input  logic   pop_i,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_o = empty_o ? entry_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/counter_wrap_monitor.sv
// Observer for the up/down load counter: predicts each step, classifies wraps,
// direction changes and jumps, and queues them behind a valid/ready FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_PRIME | first cycle after reset; sampling registers fill, no events
// ST_RUN   | every cycle classified against the predicted counter value
module counter_wrap_monitor
    import counter_mon_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int DEPTH = EV_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_out,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_load,
    input  logic             cnt_is_up,
    output logic             ev_valid,
    input  logic             ev_ready,
    output ev_kind_t         ev_kind,
    output logic [WIDTH-1:0] ev_value,
    output logic [7:0]       wrap_count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] in_q;
    logic             load_q;
    logic             up_q;

    mon_state_t       state_q, state_d;
    logic             last_dir_q, last_dir_d;
    logic             dir_valid_q, dir_valid_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] exp_val;
    logic             wrap_up;
    logic             wrap_dn;
    ev_kind_t         kind_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    ev_entry_t        push_entry;
    ev_entry_t        head;

    // Predicted value of the counter given what it consumed at the last edge.
    always_comb begin
        exp_val = prev_q;
        if (up_q) begin
            exp_val = (load_q && (prev_q == MAX)) ? in_q : prev_q + WIDTH'(1);
        end else begin
            exp_val = (load_q && (prev_q == in_q)) ? MAX : prev_q - WIDTH'(1);
        end
    end

    assign wrap_up = up_q && (prev_q == MAX);
    assign wrap_dn = !up_q && (load_q ? (prev_q == in_q) : (prev_q == '0));

    always_comb begin
        state_d     = state_q;
        kind_d      = EV_NONE;
        last_dir_d  = last_dir_q;
        dir_valid_d = dir_valid_q;
        case (state_q)
            ST_PRIME: begin
                dir_valid_d = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_out != exp_val) begin
                    kind_d = EV_JUMP;
                end else if (wrap_up) begin
                    kind_d = EV_WRAP_UP;
                end else if (wrap_dn) begin
                    kind_d = EV_WRAP_DN;
                end else if (dir_valid_q && (up_q != last_dir_q)) begin
                    kind_d = EV_DIR;
                end
                // A jump says nothing trustworthy about direction.
                if (kind_d != EV_JUMP) begin
                    last_dir_d  = up_q;
                    dir_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase
    end

    assign push             = (kind_d != EV_NONE);
    assign pop              = ev_ready && !fifo_empty;
    assign push_entry.kind  = kind_d;
    assign push_entry.value = cnt_out;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (is_wrap(kind_d) && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
        ovf_d = ovf_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q      <= '0;
            in_q        <= '0;
            load_q      <= 1'b0;
            up_q        <= 1'b0;
            state_q     <= ST_PRIME;
            last_dir_q  <= 1'b0;
            dir_valid_q <= 1'b0;
            wrap_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            prev_q      <= cnt_out;
            in_q        <= cnt_in;
            load_q      <= cnt_load;
            up_q        <= cnt_is_up;
            state_q     <= state_d;
            last_dir_q  <= last_dir_d;
            dir_valid_q <= dir_valid_d;
            wrap_cnt_q  <= wrap_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    event_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (ev_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .full_o      (fifo_full),
        .pop_i       (ev_ready),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign ev_valid   = !fifo_empty;
    assign ev_kind    = head.kind;
    assign ev_value   = head.value;
    assign wrap_count = wrap_cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Bench for counter_wrap_monitor: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_counter_wrap_monitor;
    import counter_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cnt_out, cnt_in;
    logic       cnt_load, cnt_is_up, ev_ready;
    logic       ev_valid;
    ev_kind_t   ev_kind;
    logic [2:0] ev_value;
    logic [7:0] wrap_count;
    logic       overflow;

    counter_wrap_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_out    (cnt_out),
        .cnt_in     (cnt_in),
        .cnt_load   (cnt_load),
        .cnt_is_up  (cnt_is_up),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_kind    (ev_kind),
        .ev_value   (ev_value),
        .wrap_count (wrap_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int value;
    } mev_t;

    mev_t q[$];
    int   m_wrap;
    bit   m_ovf, m_prime, m_dv, m_last, m_load, m_up;
    int   m_prev, m_in;

    logic [2:0] drv_out, drv_in;
    logic       drv_load, drv_up;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
        end
    endtask

    // Counter behaviour: value after one edge, modulo 8.
    function automatic logic [2:0] nxt(input logic [2:0] p, input logic [2:0] i,
                                       input logic l, input logic u);
        int v;
        if (u) v = (l && p == 3'd7) ? int'(i) : (int'(p) + 1) % 8;
        else   v = (l && p == i)    ? 7       : (int'(p) + 7) % 8;
        return v[2:0];
    endfunction

    task automatic model_edge(input logic rstn, input logic [2:0] out, input logic [2:0] inv,
                              input logic ld, input logic up, input logic rdy);
        int   k;
        int   e;
        bit   full, pop;
        mev_t tmp;
        if (!rstn) begin
            q.delete();
            m_wrap = 0; m_ovf = 0; m_prime = 1; m_dv = 0;
            return;
        end
        k = 0;
        if (!m_prime) begin
            e = int'(nxt(m_prev[2:0], m_in[2:0], m_load, m_up));
            if (int'(out) != e)                                   k = 4;
            else if (m_up && m_prev == 7)                         k = 1;
            else if (!m_up && (m_load ? m_prev == m_in : m_prev == 0)) k = 2;
            else if (m_dv && m_up != m_last)                      k = 3;
        end
        full = (q.size() == 4);
        pop  = (q.size() > 0) && rdy;
        if (pop) tmp = q.pop_front();
        if (k != 0) begin
            if (!full || pop) q.push_back('{k, int'(out)});
            else              m_ovf = 1;
        end
        if ((k == 1 || k == 2) && m_wrap < 255) m_wrap++;
        if (m_prime)      m_dv = 0;
        else if (k != 4) begin m_last = m_up; m_dv = 1; end
        m_prime = 0;
        m_prev = int'(out); m_in = int'(inv); m_load = ld; m_up = up;
    endtask

    task automatic check_outs();
        chk("ev_valid", ev_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("ev_kind", ev_kind, q[0].kind);
            chk("ev_value", ev_value, q[0].value);
        end else begin
            chk("ev_kind_idle", ev_kind, 0);
            chk("ev_value_idle", ev_value, 0);
        end
        chk("wrap_count", wrap_count, m_wrap);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step(input logic rstn, input logic [2:0] out, input logic [2:0] inv,
                        input logic ld, input logic up, input logic rdy);
        rst_n = rstn; cnt_out = out; cnt_in = inv; cnt_load = ld; cnt_is_up = up; ev_ready = rdy;
        drv_out = out; drv_in = inv; drv_load = ld; drv_up = up;
        model_edge(rstn, out, inv, ld, up, rdy);
        @(negedge clk);
        check_outs();
    endtask

    task automatic auto_step(input logic [2:0] inv, input logic ld, input logic up, input logic rdy);
        step(1'b1, nxt(drv_out, drv_in, drv_load, drv_up), inv, ld, up, rdy);
    endtask

    task automatic do_reset();
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] o;
        m_wrap = 0; m_ovf = 0; m_prime = 1; m_dv = 0; m_last = 0;
        m_prev = 0; m_in = 0; m_load = 0; m_up = 0;
        rst_n = 1'b0; cnt_out = '0; cnt_in = '0; cnt_load = 0; cnt_is_up = 1; ev_ready = 0;
        drv_out = '0; drv_in = '0; drv_load = 0; drv_up = 1;
        @(negedge clk);
        do_reset();
        do_reset();
        chk("reset_valid", ev_valid, 0);
        chk("reset_wrap", wrap_count, 0);

        // Full up-count lap: one wrap on 7 -> 0.
        step(1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        repeat (8) auto_step(3'd0, 1'b0, 1'b1, 1'b0);
        chk("t1_kind", ev_kind, EV_WRAP_UP);
        chk("t1_value", ev_value, 0);
        chk("t1_wrap", wrap_count, 1);
        repeat (2) auto_step(3'd0, 1'b0, 1'b1, 1'b1);

        // Direction change 4 -> 3.
        do_reset();
        step(1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0);
        auto_step(3'd0, 1'b0, 1'b0, 1'b0);
        chk("t2_no_first", ev_valid, 0);
        auto_step(3'd0, 1'b0, 1'b0, 1'b0);
        chk("t2_kind", ev_kind, EV_DIR);
        chk("t2_value", ev_value, 3);

        // Loaded down-count wraps to MAX when reaching the load value.
        do_reset();
        step(1'b1, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0);
        repeat (3) auto_step(3'd2, 1'b1, 1'b0, 1'b0);
        chk("t3_kind", ev_kind, EV_WRAP_DN);
        chk("t3_value", ev_value, 7);
        chk("t3_wrap", wrap_count, 1);

        // Jump, then a normal step in the same direction raises nothing.
        do_reset();
        step(1'b1, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0);
        auto_step(3'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("t4_kind", ev_kind, EV_JUMP);
        chk("t4_value", ev_value, 5);
        auto_step(3'd0, 1'b0, 1'b1, 1'b1);
        chk("t4_no_dir", ev_valid, 0);

        // Six jumps with no consumer: four queued, overflow, then drain.
        do_reset();
        step(1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            o = drv_out + 3'd4;
            step(1'b1, o, 3'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("t5_overflow", overflow, 1);
        repeat (4) auto_step(3'd0, 1'b0, 1'b1, 1'b1);
        chk("t5_drained", ev_valid, 0);

        // Reset with two events queued and wrap_count at three.
        do_reset();
        step(1'b1, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0);
        auto_step(3'd0, 1'b0, 1'b0, 1'b0);
        auto_step(3'd0, 1'b0, 1'b1, 1'b0);
        auto_step(3'd0, 1'b0, 1'b1, 1'b1);
        chk("t6_wrap3", wrap_count, 3);
        do_reset();
        chk("t6_valid", ev_valid, 0);
        chk("t6_wrap0", wrap_count, 0);
        chk("t6_ovf0", overflow, 0);
        step(1'b1, 3'd7, 3'd0, 1'b0, 1'b1, 1'b1);
        auto_step(3'd0, 1'b0, 1'b1, 1'b1);
        chk("t6_prime_ok", wrap_count, 1);

        // Saturation of the wrap counter.
        do_reset();
        step(1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        repeat (2100) auto_step(3'd0, 1'b0, 1'b1, 1'b1);
        chk("t7_sat", wrap_count, 255);

        // Randomized traffic with bursts of back-pressure and rare resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] inv;
            logic       ld, up, rdy;
            inv = 3'($urandom_range(0, 7));
            ld  = 1'($urandom_range(0, 1));
            up  = 1'($urandom_range(0, 1));
            rdy = ((i / 16) % 3 != 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 9) == 0) begin
                step(1'b1, 3'($urandom_range(0, 7)), inv, ld, up, rdy);
            end else begin
                auto_step(inv, ld, up, rdy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_wrap_monitor.md
# counter_wrap_monitor

Downstream observer for the 3-bit up/down load counter. Each cycle it samples the counter's output and the control inputs that produced it, and predicts the next value with a reference model. It classifies each transition as a wrap, direction change or unexpected jump, and queues the events in a small FIFO behind a valid/ready handshake. A saturating wrap counter and a sticky overflow flag give the bench and the top level a cheap health summary.

## Interface
- WIDTH, 3, counter width; MAX = 2**WIDTH-1
- DEPTH, 4, event FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock, shared with the counter
- rst_n  in  1  synchronous, active-low reset
- cnt_out  in  WIDTH  counter output
- cnt_in  in  WIDTH  counter load value
- cnt_load  in  1  counter load control
- cnt_is_up  in  1  counter direction control
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head this cycle
- ev_kind  out  3  head event kind (ev_kind_t)
- ev_value  out  WIDTH  cnt_out value that raised the event
- wrap_count  out  8  saturating count of WRAP_UP + WRAP_DN classifications
- overflow  out  1  sticky; an event was dropped because the FIFO was full

## Operation
- **Sampling.** Every edge registers prev ← cnt_out and ctl_q ← {cnt_in, cnt_load, cnt_is_up}. These are the exact values the counter consumed at that edge.
- **States.**
  - PRIME (entered on reset): registers only, no classification; goes to RUN next edge.
  - RUN: classifies each cycle and stays in RUN until reset.
- **Expected value (exp), mod 2**WIDTH:**
  - up & load: prev==MAX ? in_q : prev+1
  - down & load: prev==in_q ? MAX : prev-1
  - up & !load: prev+1
  - down & !load: prev-1
- **Classification in RUN** (priority high→low, one event max per cycle):
  - cnt_out≠exp → EV_JUMP.
  - up_q && prev==MAX → EV_WRAP_UP.
  - !up_q && (load_q ? prev==in_q : prev==0) → EV_WRAP_DN.
  - dir_valid && up_q≠last_dir → EV_DIR.
  - otherwise EV_NONE: nothing pushed.
- **Direction tracking.**
  - On every non-JUMP RUN cycle: last_dir ← up_q, dir_valid ← 1.
  - JUMP cycles leave last_dir unchanged.
  - PRIME clears dir_valid, so the first step never raises EV_DIR.
- **wrap_count.** Increments on WRAP_UP/WRAP_DN classifications whether or not the FIFO accepts the event. Holds at 255.
- **FIFO.**
  - Entry = {kind, value = cnt_out}.
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow ← 1 (cleared only by reset).
  - Pop when ev_valid && ev_ready.
  - Order is strictly FIFO.
- **Reset values.** ev_valid=0, ev_kind=EV_NONE, ev_value=0, wrap_count=0, overflow=0; FIFO empty; state PRIME; dir_valid=0.

## Timing
- Classification is combinational on cycle c. The push happens at the edge ending cycle c, so ev_valid rises on c+1: one cycle of latency.
- ev_kind/ev_value come from registered storage and are stable while ev_valid && !ev_ready.
- When the FIFO is empty, push and pop cannot coincide (ev_valid=0).
- When full, simultaneous push and pop: both occur, count unchanged, no overflow.
- rst_n low on any edge flushes the FIFO and re-enters PRIME, overriding push and pop. The cycle after release is PRIME, so no event can reference a pre-reset value.
- Counter async reset mid-run (out → 0) is reported as EV_JUMP value 0 unless exp happens to be 0.

## Structure
- Package counter_mon_pkg holds:
  - ev_kind_t, a 3-bit enum: EV_NONE=0, EV_WRAP_UP=1, EV_WRAP_DN=2, EV_DIR=3, EV_JUMP=4.
  - ev_entry_t, a packed struct {kind, value}.
  - State enum {PRIME, RUN}.
- Sub-module event_fifo: synchronous FIFO parameterised on DEPTH and entry type. It exposes push/full and pop/empty, with a head output.
- The top level holds the sampling registers, expected-value model, classifier, direction tracker and counters.

## Test plan
- Reset, load=0, is_up=1, run 9 cycles (out 0..7,0) → exactly one EV_WRAP_UP with value 0; wrap_count=1.
- Up through 3,4, then is_up=0 (out 3) → one EV_DIR with value 3; no event on the first post-PRIME step.
- in=2, load=1, is_up=0, out 4,3,2,7 → EV_WRAP_DN with value 7; wrap_count increments.
- Force cnt_out=5 when exp=6 → EV_JUMP with value 5; last_dir unchanged, so the next normal step raises no EV_DIR.
- ev_ready=0 while 6 events occur → 4 are queued and overflow=1. Then ev_ready=1 → the first 4 events drain in order and ev_valid drops.
- rst_n=0 for 1 cycle with 2 events queued and wrap_count=3 → next cycle ev_valid=0, wrap_count=0, overflow=0, state PRIME.
